// File: rtl/sr_pulse_sequencer_if.sv
// sr_pulse_sequencer_if
//   Bundles the request, feedback and status signals of the SR pulse
//   sequencer so that the sequencer and its client connect through one port.
//
//   Signals
//     set_req, clr_req : single-cycle set / clear requests (client -> sequencer)
//     q_fb             : Q output of the downstream SR flop (client -> sequencer)
//     S, R             : set / reset drive to the flop (sequencer -> client)
//     busy             : operation in progress
//     done, err        : one-cycle completion pulses (Q matched / mismatched)
//     conflict         : one-cycle pulse, both requests seen together in IDLE
//     ok_cnt           : saturating count of successful operations
//
//   Modports
//     slave  : the sequencer side
//     master : the side that issues requests and observes status
interface sr_pulse_sequencer_if #(
   parameter int CW = 8
);
   logic          set_req;
   logic          clr_req;
   logic          q_fb;
   logic          S;
   logic          R;
   logic          busy;
   logic          done;
   logic          err;
   logic          conflict;
   logic [CW-1:0] ok_cnt;

   modport slave (
      input  set_req,
      input  clr_req,
      input  q_fb,
      output S,
      output R,
      output busy,
      output done,
      output err,
      output conflict,
      output ok_cnt
   );

   modport master (
      output set_req,
      output clr_req,
      output q_fb,
      input  S,
      input  R,
      input  busy,
      input  done,
      input  err,
      input  conflict,
      input  ok_cnt
   );
endinterface

// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer
//   Command sequencer for a clocked SR flip-flop. A single-cycle set or
//   clear request becomes an S or R pulse of PULSE_W cycles, followed by
//   GAP_W idle cycles so Q can settle. Q is then checked against the value
//   the operation should have produced, and done or err is pulsed.
//
//   Parameters
//     PULSE_W : cycles S or R is held high per operation (1..255)
//     GAP_W   : idle cycles after the pulse before Q is checked (1..255)
//     CW      : width of the successful-operation counter
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous, active-high reset
//     bus : slave side of sr_pulse_sequencer_if
//           (set_req, clr_req, q_fb in; S, R, busy, done, err, conflict,
//            ok_cnt out)
//
//   All outputs are registered. S and R both derive from the same PULSE
//   state, gated by complementary values of the latched operation, so they
//   can never be high together.
module sr_pulse_sequencer #(
   parameter int PULSE_W = 1,
   parameter int GAP_W   = 1,
   parameter int CW      = 8
) (
   input logic                  clk,
   input logic                  rst,
   sr_pulse_sequencer_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_CHECK = 2'd3;

   // Terminal counts of the phase counter, which counts 0 .. N-1.
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_W - 1);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [7:0]    cnt;
   logic [7:0]    cnt_nxt;
   logic          op_set;       // 1: SET (expect Q=1), 0: CLR (expect Q=0)
   logic          op_set_nxt;

   logic          s_q;
   logic          r_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          conflict_q;
   logic [CW-1:0] ok_q;

   logic          q_match;
   logic          in_check;

   // Counter increment that holds at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      logic [CW-1:0] one;
      one = {{(CW-1){1'b0}}, 1'b1};
      if (v == {CW{1'b1}}) begin
         return v;
      end
      return v + one;
   endfunction

   assign in_check = (state == ST_CHECK);
   assign q_match  = (bus.q_fb == op_set);

   // Next-state logic
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      op_set_nxt = op_set;
      case (state)
         ST_IDLE: begin
            // Exactly one request starts an operation; both together is a
            // conflict and nothing starts.
            if (bus.set_req ^ bus.clr_req) begin
               op_set_nxt = bus.set_req;
               cnt_nxt    = 8'd0;
               state_nxt  = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (cnt == PULSE_LAST) begin
               cnt_nxt   = 8'd0;
               state_nxt = ST_GAP;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nxt   = 8'd0;
               state_nxt = ST_CHECK;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         ST_CHECK: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // State and registered outputs. Drives lag the state by one edge: an
   // edge taken in PULSE raises S/R for the following cycle, so the pulse
   // occupies the cycles after the PULSE_W edges spent in PULSE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 8'd0;
         op_set     <= 1'b0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         conflict_q <= 1'b0;
         ok_q       <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         op_set     <= op_set_nxt;
         s_q        <= (state == ST_PULSE) &&  op_set;
         r_q        <= (state == ST_PULSE) && !op_set;
         // Follows the next state so busy drops in the cycle done/err rises.
         busy_q     <= (state_nxt != ST_IDLE);
         done_q     <= in_check &&  q_match;
         err_q      <= in_check && !q_match;
         conflict_q <= (state == ST_IDLE) && bus.set_req && bus.clr_req;
         if (in_check && q_match) begin
            ok_q <= sat_inc(ok_q);
         end
      end
   end

   assign bus.S        = s_q;
   assign bus.R        = r_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.conflict = conflict_q;
   assign bus.ok_cnt   = ok_q;

endmodule

// File: tb/tb_sr_pulse_sequencer.sv
// tb_sr_pulse_sequencer
//   Bench for sr_pulse_sequencer with PULSE_W=2, GAP_W=1, CW=2. Q feedback
//   comes from a behavioural SR flop, or from a forced value. Each request
//   pushes its expected completion (edge, done/err, ok_cnt) onto a queue;
//   a negedge monitor pops and compares when done or err appears.
module tb_sr_pulse_sequencer;

   localparam int PW   = 2;
   localparam int GW   = 1;
   localparam int CW   = 2;
   localparam int LAT  = PW + GW + 1;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct {
      int due;
      bit exp_done;
      int exp_cnt;
   } exp_t;

   logic clk;
   logic rst;
   logic flop_q;
   logic force_en;
   logic force_val;
   int   cyc;
   int   checks;
   int   failures;
   int   exp_ok;
   exp_t sb[$];

   sr_pulse_sequencer_if #(.CW(CW)) bus ();

   sr_pulse_sequencer #(
      .PULSE_W (PW),
      .GAP_W   (GW),
      .CW      (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc    = 0;
      flop_q = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream clocked SR flop
   always @(posedge clk) begin
      if (bus.S === 1'b1) flop_q <= 1'b1;
      else if (bus.R === 1'b1) flop_q <= 1'b0;
   end

   assign bus.q_fb = force_en ? force_val : flop_q;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int due, input bit match);
      exp_t e;
      if (match) exp_ok = (exp_ok == MAXC) ? MAXC : exp_ok + 1;
      e.due      = due;
      e.exp_done = match;
      e.exp_cnt  = exp_ok;
      sb.push_back(e);
   endtask

   task automatic check_idle_zero(input string tag);
      check_val(tag, {25'd0, bus.S, bus.R, bus.busy, bus.done, bus.err,
                      bus.conflict, 1'b0} | 32'(bus.ok_cnt), 32'd0);
   endtask

   // One request, then per-cycle checks of S, R and busy up to the
   // completion cycle.
   task automatic run_single(input bit set_op, input bit match);
      @(negedge clk);
      bus.set_req = set_op;
      bus.clr_req = !set_op;
      push_exp(cyc + 1 + LAT, match);
      @(negedge clk);
      bus.set_req = 1'b0;
      bus.clr_req = 1'b0;
      for (int j = 0; j <= LAT; j++) begin
         check_val($sformatf("S_j%0d", j), 32'(bus.S), 32'(set_op && j >= 1 && j <= PW));
         check_val($sformatf("R_j%0d", j), 32'(bus.R), 32'(!set_op && j >= 1 && j <= PW));
         check_val($sformatf("busy_j%0d", j), 32'(bus.busy), 32'(j < LAT));
         @(negedge clk);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      check_val("s_and_r", 32'(bus.S & bus.R), 32'd0);
      if (bus.done === 1'b1 || bus.err === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("spurious_done_err", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            check_val("latency", 32'(cyc), 32'(sb[0].due));
            check_val("done", 32'(bus.done), 32'(sb[0].exp_done));
            check_val("err", 32'(bus.err), 32'(!sb[0].exp_done));
            check_val("ok_cnt", 32'(bus.ok_cnt), 32'(sb[0].exp_cnt));
            sb.delete(0);
         end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
         check_val("missing_done_err", 32'(cyc), 32'(sb[0].due));
         sb.delete(0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      checks      = 0;
      failures    = 0;
      exp_ok      = 0;
      rst         = 1'b1;
      force_en    = 1'b0;
      force_val   = 1'b0;
      bus.set_req = 1'b0;
      bus.clr_req = 1'b0;

      // Reset held for two edges with random requests
      @(negedge clk);
      check_idle_zero("rst_c0");
      bus.set_req = 1'($urandom_range(0, 1));
      bus.clr_req = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_idle_zero("rst_c1");
      bus.set_req = 1'b1;
      bus.clr_req = 1'b0;
      @(negedge clk);
      check_idle_zero("rst_c2");
      rst         = 1'b0;
      bus.set_req = 1'b0;
      @(negedge clk);
      check_idle_zero("rst_release");

      // Set with real flop feedback
      run_single(1'b1, 1'b1);
      check_val("q_after_set", 32'(flop_q), 32'd1);

      // Clear with Q stuck at 1
      force_en  = 1'b1;
      force_val = 1'b1;
      run_single(1'b0, 1'b0);
      force_en  = 1'b0;
      check_val("q_after_clr", 32'(flop_q), 32'd0);

      // Conflict
      @(negedge clk);
      bus.set_req = 1'b1;
      bus.clr_req = 1'b1;
      @(negedge clk);
      check_val("conflict_hi", 32'(bus.conflict), 32'd1);
      check_val("conflict_sr", 32'({bus.S, bus.R, bus.busy}), 32'd0);
      bus.set_req = 1'b0;
      bus.clr_req = 1'b0;
      @(negedge clk);
      check_val("conflict_lo", 32'(bus.conflict), 32'd0);
      check_val("conflict_busy", 32'(bus.busy), 32'd0);

      // Request held through busy cycles starts only one operation
      @(negedge clk);
      bus.set_req = 1'b1;
      push_exp(cyc + 1 + LAT, 1'b1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus.set_req = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      check_val("single_op", 32'(sb.size()), 32'd0);

      // Reset during PULSE
      @(negedge clk);
      bus.set_req = 1'b1;
      push_exp(cyc + 1 + LAT, 1'b1);
      @(negedge clk);
      bus.set_req = 1'b0;
      @(negedge clk);
      check_val("S_before_rst", 32'(bus.S), 32'd1);
      rst = 1'b1;
      sb.delete();
      exp_ok = 0;
      @(negedge clk);
      rst = 1'b0;
      check_val("S_after_rst", 32'(bus.S), 32'd0);
      check_val("busy_after_rst", 32'(bus.busy), 32'd0);
      check_val("ok_after_rst", 32'(bus.ok_cnt), 32'd0);
      repeat (LAT + 2) @(negedge clk);
      run_single(1'b1, 1'b1);

      // Back-to-back sets with request held; counter saturates at 3
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      exp_ok = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n = cyc;
      bus.set_req = 1'b1;
      for (int i = 0; i < 5; i++) push_exp(n + 1 + i * (LAT + 1) + LAT, 1'b1);
      repeat (4 * (LAT + 1) + 1) @(negedge clk);
      bus.set_req = 1'b0;
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      check_val("drain", 32'(sb.size()), 32'd0);
      check_val("ok_final", 32'(bus.ok_cnt), 32'(MAXC));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_pulse_sequencer.md
# sr_pulse_sequencer

Command sequencer that sits directly upstream of the clocked SR flip-flop and drives its S and R inputs. It turns single-cycle set/clear requests into S or R pulses of programmable width, then a guard gap. It checks the flop's Q feedback against the expected value and reports done or err. By construction it never drives the forbidden S=R=1 combination.

## Interface
- PULSE_W, 1, number of cycles S or R is held high per operation (1..255)
- GAP_W, 1, number of idle cycles (S=R=0) after the pulse, before Q is checked (1..255)
- CW, 8, width of the successful-operation counter
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset, synchronous, active-high
- set_req  in  1  request to set the flop; sampled in IDLE only
- clr_req  in  1  request to clear the flop; sampled in IDLE only
- q_fb  in  1  Q output of the downstream SR flop
- S  out  1  set drive to the flop
- R  out  1  reset drive to the flop
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: operation finished and q_fb matched
- err  out  1  one-cycle pulse: operation finished and q_fb mismatched
- conflict  out  1  one-cycle pulse: set_req and clr_req were both high in IDLE
- ok_cnt  out  CW  saturating count of done pulses

## Operation
- All outputs are registered. The FSM has four states: IDLE, PULSE, GAP, CHECK.
- Reset values: S=0, R=0, busy=0, done=0, err=0, conflict=0, ok_cnt=0, state=IDLE, internal counters 0.
- IDLE, set_req=1 and clr_req=0: latch op=SET (expected Q=1) and go to PULSE.
- IDLE, clr_req=1 and set_req=0: latch op=CLR (expected Q=0) and go to PULSE.
- IDLE, both requests high: pulse conflict for one cycle, stay in IDLE, drive no S/R.
- PULSE: S=1 (SET) or R=1 (CLR) for exactly PULSE_W cycles, then go to GAP.
- GAP: S=R=0 for exactly GAP_W cycles, then go to CHECK.
- CHECK: one cycle. Compare q_fb with the expected value, then return to IDLE. The next cycle has done=1 if they match, otherwise err=1.
- busy=1 in PULSE, GAP and CHECK; busy=0 in IDLE.
- Requests arriving while busy are ignored; there is no queue.
- The IDLE cycle that carries done/err also accepts a new request, so operations can run back-to-back.
- ok_cnt increments on each done and holds at 2^CW-1. err does not change ok_cnt.
- Invariant: S and R are never both 1 in any cycle, including reset and parameter extremes.

## Timing
- Request sampled at edge k:
  - S/R high in the cycles after edges k+1 .. k+PULSE_W.
  - Gap in cycles k+PULSE_W+1 .. k+PULSE_W+GAP_W.
  - CHECK samples q_fb at edge k+PULSE_W+GAP_W+1.
  - done/err high in the cycle after edge k+PULSE_W+GAP_W+1.
- Total latency from request edge to done/err = PULSE_W+GAP_W+1 edges.
- busy rises one cycle after acceptance and falls in the same cycle done/err rises.
- conflict is high in the cycle after the edge that sampled both requests.
- Reset mid-operation (any state): at the edge where rst=1, S=R=0, busy=0, and ok_cnt=0. No done/err is produced for the aborted operation, and the FSM returns to IDLE.
- rst has priority over any request in the same cycle.
- GAP_W≥1 gives the clocked flop one full cycle for Q to settle before CHECK.

## Test plan
- rst high for 2 cycles with random requests: all outputs 0 throughout and on the first cycle after release.
- PULSE_W=2, GAP_W=1, q_fb wired to a real SR flop, single-cycle set_req at edge k: S=1 for exactly 2 cycles, R=0 throughout, done=1 after edge k+4, Q=1, ok_cnt=1.
- clr_req with q_fb forced to 1: R=1 for PULSE_W cycles, err=1 once, done=0, ok_cnt unchanged.
- set_req=clr_req=1 in IDLE: conflict=1 for one cycle, S=R=0, busy=0. Then set_req during busy: no second operation starts.
- rst asserted during PULSE: S drops the next cycle, no done/err, ok_cnt=0, and a following set_req completes normally.
- CW=2, five back-to-back successful sets: each new request accepted in the done cycle, ok_cnt reads 1,2,3,3,3, and S&R==0 holds in every cycle of the run.
